uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, centre-sampling bit timer,
// one-cycle rx_valid / frame_err pulses and a BREAK state for a held-low line.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Frame FSM: half-bit wait to the start-bit centre, then one full bit
    // period between samples; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            cnt_q     <= FULL_LOAD;
                            bit_idx_q <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: ignore it.
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q   <= S_STOP;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line without re-triggering.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16: nominal, back-to-back, glitch,
// framing error/break, mid-frame reset and bit-period tolerance.
module tb_uart_rx;

    localparam int unsigned BAUD_DIV = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;

    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         data_change_err = 0;
    int         busy_low_cnt = 0;
    int         valid_cyc = 0;
    int         prev_valid_cyc = 0;
    logic [7:0] last_valid_data = 8'h00;
    logic [7:0] prev_valid_data = 8'h00;
    logic [7:0] prev_rx_data = 8'h00;
    int         busy_from = 0;
    int         busy_to = 0;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: incremented on every rising edge.
    always @(posedge clk) cyc++;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            prev_valid_cyc  = valid_cyc;
            valid_cyc       = cyc;
            prev_valid_data = last_valid_data;
            last_valid_data = rx_data;
        end
        if (frame_err) ferr_cnt++;
        if (rx_valid && frame_err) both_cnt++;
        if (rst_n && !rx_valid && (rx_data !== prev_rx_data)) data_change_err++;
        prev_rx_data = rx_data;
        if (cyc >= busy_from && cyc < busy_to && !busy) busy_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, stop; even-numbered bits (start = 0)
    // last p_even clocks and odd-numbered bits p_odd clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int p_even, input int p_odd);
        send_bit(1'b0, p_even);
        for (int j = 0; j < 8; j++) begin
            send_bit(d[j], ((j + 1) % 2 == 0) ? p_even : p_odd);
        end
        send_bit(stop_v, p_odd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int v0;
        int f0;

        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_bit(1'b1, 10);

        // Nominal 0xA5 with latency measured from the sync-flop-1 edge.
        v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
        busy_from = t0 + 3;
        busy_to   = t0 + 155;
        send_frame(8'hA5, 1'b1, 16, 16);
        send_bit(1'b1, 8);
        check("nominal valid count", 32'(valid_cnt - v0), 32'd1);
        check("nominal rx_data", 32'(rx_data), 32'hA5);
        check("nominal latency", 32'(valid_cyc - t0), 32'd155);
        check("nominal frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("nominal busy in frame", 32'(busy_low_cnt), 32'd0);
        check("nominal busy after", 32'(busy), 32'h0);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 16, 16);
        send_frame(8'hFF, 1'b1, 16, 16);
        send_bit(1'b1, 8);
        check("b2b valid count", 32'(valid_cnt - v0), 32'd2);
        check("b2b first data", 32'(prev_valid_data), 32'h00);
        check("b2b second data", 32'(last_valid_data), 32'hFF);
        check("b2b spacing", 32'(valid_cyc - prev_valid_cyc), 32'd160);

        // Three-clock glitch: START check at its centre returns to IDLE.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b0, 3);
        send_bit(1'b1, 7);
        check("glitch busy in START", 32'(busy), 32'h1);
        send_bit(1'b1, 1);
        check("glitch back to IDLE", 32'(busy), 32'h0);
        send_bit(1'b1, 30);
        check("glitch no valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch no frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("glitch rx_data kept", 32'(rx_data), 32'hFF);

        // Framing error on 0x3C, then line held low (BREAK).
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 16, 16);
        send_bit(1'b0, 64);
        check("ferr pulse count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr no valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr rx_data kept", 32'(rx_data), 32'hFF);
        check("ferr busy while low", 32'(busy), 32'h1);
        send_bit(1'b1, 4);
        check("ferr busy after release", 32'(busy), 32'h0);
        check("ferr single pulse", 32'(ferr_cnt - f0), 32'd1);
        send_bit(1'b1, 8);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 16, 16);
        send_bit(1'b1, 8);
        check("after break valid", 32'(valid_cnt - v0), 32'd1);
        check("after break data", 32'(rx_data), 32'h81);

        // Reset pulsed in the middle of bit 4 of 0x5A.
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h00);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bit(1'b1, 40);
        check("midreset no valid", 32'(valid_cnt - v0), 32'd0);
        check("midreset no frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("midreset busy idle", 32'(busy), 32'h0);
        send_frame(8'hC3, 1'b1, 16, 16);
        send_bit(1'b1, 8);
        check("post reset valid", 32'(valid_cnt - v0), 32'd1);
        check("post reset data", 32'(rx_data), 32'hC3);

        // Bit periods of 15 and 17 clk alternating, both phase orders.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 15, 17);
        send_bit(1'b1, 20);
        check("tol 15/17 valid", 32'(valid_cnt - v0), 32'd1);
        check("tol 15/17 data", 32'(rx_data), 32'h55);
        send_frame(8'hAA, 1'b1, 16, 16);
        send_bit(1'b1, 20);
        check("tol separator data", 32'(rx_data), 32'hAA);
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 17, 15);
        send_bit(1'b1, 20);
        check("tol 17/15 valid", 32'(valid_cnt - v0), 32'd1);
        check("tol 17/15 data", 32'(rx_data), 32'h55);
        check("tol no frame_err", 32'(ferr_cnt - f0), 32'd0);

        // Whole-run invariants.
        check("valid and frame_err together", 32'(both_cnt), 32'd0);
        check("rx_data changed off valid", 32'(data_change_err), 32'd0);
        check("busy low inside frame", 32'(busy_low_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
